// File: rtl/change_dispenser_if.sv
// Request handshake and payout status bundle between the vending controller
// and the change dispenser.
interface change_dispenser_if #(
    parameter int AMT_W = 7
);
    logic             req_valid;
    logic [AMT_W-1:0] req_amount;
    logic             req_ready;
    logic [3:0]       coin_out;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] short_amount;

    modport master (
        output req_valid, req_amount,
        input  req_ready, coin_out, busy, done, short, short_amount
    );

    modport slave (
        input  req_valid, req_amount,
        output req_ready, coin_out, busy, done, short, short_amount
    );
endinterface

// File: rtl/change_dispenser.sv
// Greedy coin payout over four denomination tubes with per-tube inventory,
// shortfall reporting and a saturating refill port.
module change_dispenser #(
    parameter int AMT_W    = 7,
    parameter int INV_W    = 6,
    parameter int DEN0     = 10,
    parameter int DEN1     = 5,
    parameter int DEN2     = 2,
    parameter int DEN3     = 1,
    parameter int INV_INIT = 8,
    parameter int COIN_GAP = 2
) (
    input  logic               clk,
    input  logic               rst,
    change_dispenser_if.slave  bus,
    input  logic               refill_en,
    input  logic [1:0]         refill_tube,
    input  logic [INV_W-1:0]   refill_qty,
    output logic [INV_W-1:0]   inv0,
    output logic [INV_W-1:0]   inv1,
    output logic [INV_W-1:0]   inv2,
    output logic [INV_W-1:0]   inv3
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EMIT,
        S_GAP,
        S_FINISH
    } state_t;

    localparam int GAP_W = (COIN_GAP > 1) ? $clog2(COIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (COIN_GAP > 0) ? GAP_W'(COIN_GAP - 1) : '0;
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [AMT_W-1:0] DEN [4] = '{AMT_W'(DEN0), AMT_W'(DEN1), AMT_W'(DEN2), AMT_W'(DEN3)};
    localparam logic [INV_W-1:0] INV_RST = INV_W'(INV_INIT);
    localparam logic [INV_W:0]   INV_ONE = (INV_W+1)'(1);

    state_t             state;
    logic [AMT_W-1:0]   remaining;
    logic [1:0]         sel;
    logic [GAP_W-1:0]   gap_cnt;
    logic [INV_W-1:0]   inv     [4];
    logic [INV_W-1:0]   inv_nxt [4];
    logic [INV_W:0]     inv_sum [4];
    logic               pick_ok;
    logic [1:0]         pick;

    // Largest denomination first: lowest index that fits and is stocked.
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!pick_ok && (DEN[i] <= remaining) && (inv[i] != '0)) begin
                pick_ok = 1'b1;
                pick    = 2'(i);
            end
        end
    end

    // Eject decrement and refill combine before saturation, so a same-tube
    // refill during EMIT yields min(inv-1+qty, max); sum <= 2*max never wraps.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            inv_sum[i] = {1'b0, inv[i]};
            if ((state == S_EMIT) && (sel == 2'(i)))
                inv_sum[i] = inv_sum[i] - INV_ONE;
            if (refill_en && (refill_tube == 2'(i)))
                inv_sum[i] = inv_sum[i] + {1'b0, refill_qty};
            inv_nxt[i] = inv_sum[i][INV_W] ? '1 : inv_sum[i][INV_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            remaining        <= '0;
            sel              <= '0;
            gap_cnt          <= '0;
            bus.coin_out     <= '0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.short        <= 1'b0;
            bus.short_amount <= '0;
            for (int unsigned i = 0; i < 4; i++)
                inv[i] <= INV_RST;
        end else begin
            for (int unsigned i = 0; i < 4; i++)
                inv[i] <= inv_nxt[i];
            bus.coin_out <= '0;
            bus.done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        remaining        <= bus.req_amount;
                        bus.short        <= 1'b0;
                        bus.short_amount <= '0;
                        bus.busy         <= 1'b1;
                        state            <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (remaining == '0) begin
                        bus.done <= 1'b1;
                        state    <= S_FINISH;
                    end else if (pick_ok) begin
                        sel          <= pick;
                        bus.coin_out <= 4'b0001 << pick;
                        state        <= S_EMIT;
                    end else begin
                        bus.short        <= 1'b1;
                        bus.short_amount <= remaining;
                        bus.done         <= 1'b1;
                        state            <= S_FINISH;
                    end
                end
                S_EMIT: begin
                    remaining <= remaining - DEN[sel];
                    if (COIN_GAP > 0) begin
                        gap_cnt <= GAP_LOAD;
                        state   <= S_GAP;
                    end else begin
                        state <= S_SELECT;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0)
                        state <= S_SELECT;
                    else
                        gap_cnt <= gap_cnt - GAP_ONE;
                end
                S_FINISH: begin
                    bus.busy <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (state == S_IDLE) && !rst;

    assign inv0 = inv[0];
    assign inv1 = inv[1];
    assign inv2 = inv[2];
    assign inv3 = inv[3];
endmodule
